// File: rtl/sr_lock_pkg.sv
// sr_lock_pkg: shared state encodings and requester sizing for the lock arbiter.
package sr_lock_pkg;
   localparam int NREQ = 4;
   localparam int IW = 2;
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_e;
endpackage

// File: rtl/sr_flag.sv
// sr_flag: synchronous set/reset flag, reset input has priority over set.
module sr_flag (
   input  logic CK,
   input  logic RB,
   input  logic S,
   input  logic R,
   output logic Q,
   output logic QB
);
   logic q_q;
   always_ff @(posedge CK) begin
      if (!RB)   q_q <= 1'b0;
      else if (R) q_q <= 1'b0;
      else if (S) q_q <= 1'b1;
   end
   assign Q  = q_q;
   assign QB = ~q_q;
endmodule

// File: rtl/sr_lock_arbiter.sv
// sr_lock_arbiter: round-robin lock arbiter with bounded hold time and a forced-release pulse.
module sr_lock_arbiter
   import sr_lock_pkg::*;
#(
   parameter int HOLD_MAX = 15,
   parameter int CW = 8
) (
   input  logic            CK,
   input  logic            RB,
   input  logic [NREQ-1:0] REQ,
   output logic [NREQ-1:0] GNT,
   output logic [IW-1:0]   OWNER,
   output logic            BUSY,
   output logic            TIMEOUT
);
   state_e          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d, owner_q, owner_d, sel;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            to_q, to_d, set_s, clr_r, found, unused_qb;
   always_comb begin
      sel   = ptr_q;
      found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found && REQ[ptr_q + IW'(i)]) begin
            sel   = ptr_q + IW'(i);
            found = 1'b1;
         end
      end
   end
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      to_d    = 1'b0;
      set_s   = 1'b0;
      clr_r   = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (|REQ) begin
               state_d = GRANT;
               owner_d = sel;
               set_s   = 1'b1;
            end
         end
         GRANT: begin
            cnt_d = cnt_q + CW'(1);
            // Owner dropping its request wins over the hold limit: no timeout then.
            if (!REQ[owner_q] || cnt_q == CW'(HOLD_MAX - 1)) begin
               state_d = RELEASE;
               clr_r   = 1'b1;
               to_d    = REQ[owner_q];
            end
         end
         RELEASE: begin
            state_d = IDLE;
            ptr_d   = owner_q + IW'(1);
            cnt_d   = '0;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge CK) begin
      if (!RB) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         cnt_q   <= '0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         to_q    <= to_d;
      end
   end
   sr_flag u_busy (
      .CK (CK),
      .RB (RB),
      .S  (set_s),
      .R  (clr_r),
      .Q  (BUSY),
      .QB (unused_qb)
   );
   assign GNT     = (state_q == GRANT) ? (NREQ'(1) << owner_q) : '0;
   assign OWNER   = owner_q;
   assign TIMEOUT = to_q;
endmodule
